// File: rtl/booth_multiplier.sv
// Sequential radix-2 Booth multiplier for two's-complement operands.
// X and Y are captured on start. One Booth step runs per clock.
// The 2*WIDTH-bit signed product appears on Z with a one-cycle valid strobe.
//
// state  | meaning
// -------+---------------------------------------------------------------
// S_IDLE | waiting for start; Z holds the last product
// S_RUN  | one Booth iteration per edge; the last edge writes Z and valid
module booth_multiplier #(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   X,
  input  logic [WIDTH-1:0]   Y,
  output logic               valid,
  output logic [2*WIDTH-1:0] Z
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t r_state, r_state_nxt;

  // The accumulator has one guard bit, so subtracting M = -2^(WIDTH-1) cannot overflow.
  logic [WIDTH:0]       r_a;
  logic [WIDTH:0]       r_m;
  logic [WIDTH-1:0]     r_q;
  logic                 r_q1;
  logic [CW-1:0]        r_count;
  logic                 r_valid;
  logic [2*WIDTH-1:0]   r_z;

  logic                 w_load;
  logic                 w_step;
  logic                 w_last;
  logic [WIDTH:0]       w_sum;
  logic [WIDTH:0]       w_a_sh;
  logic [WIDTH-1:0]     w_q_sh;
  logic                 w_q1_sh;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= r_state_nxt;
  end

  // Next state and datapath strobes.
  // w_last fires on the edge that completes the final iteration.
  always_comb begin
    r_state_nxt = r_state;
    w_load      = 1'b0;
    w_step      = 1'b0;
    w_last      = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (start) begin
          w_load      = 1'b1;
          r_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        w_step = 1'b1;
        if (r_count == CW'(1)) begin
          w_last      = 1'b1;
          r_state_nxt = S_IDLE;
        end
      end
      default: r_state_nxt = S_IDLE;
    endcase
  end

  // Booth add or subtract selected by {Q[0], q_1}, then arithmetic right shift of {A, Q, q_1}
  always_comb begin
    w_sum = r_a;
    unique case ({r_q[0], r_q1})
      2'b01:   w_sum = r_a + r_m;
      2'b10:   w_sum = r_a - r_m;
      default: w_sum = r_a;
    endcase
    w_a_sh  = {w_sum[WIDTH], w_sum[WIDTH:1]};
    w_q_sh  = {w_sum[0], r_q[WIDTH-1:1]};
    w_q1_sh = r_q[0];
  end

  // Operand capture and iteration registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a     <= '0;
      r_m     <= '0;
      r_q     <= '0;
      r_q1    <= 1'b0;
      r_count <= '0;
    end else if (w_load) begin
      r_a     <= '0;
      r_m     <= {X[WIDTH-1], X};
      r_q     <= Y;
      r_q1    <= 1'b0;
      r_count <= CW'(WIDTH);
    end else if (w_step) begin
      r_a     <= w_a_sh;
      r_q     <= w_q_sh;
      r_q1    <= w_q1_sh;
      r_count <= r_count - CW'(1);
    end
  end

  // Product register and valid strobe. Z changes only when a multiply completes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_z     <= '0;
    end else begin
      r_valid <= w_last;
      if (w_last) r_z <= {w_a_sh[WIDTH-1:0], w_q_sh};
    end
  end

  assign valid = r_valid;
  assign Z     = r_z;

endmodule

// File: tb/tb_booth_multiplier.sv
// Scoreboard bench for booth_multiplier (WIDTH=4).
// The driver pushes expected products into a queue.
// A forked monitor pops one entry and compares it on every valid.
module tb_booth_multiplier;

  logic       clk;
  logic       rst;
  logic       start;
  logic [3:0] X;
  logic [3:0] Y;
  logic       valid;
  logic [7:0] Z;

  int checks = 0;
  int errors = 0;
  logic [7:0] sb[$];
  logic [7:0] last_z = 8'h00;

  booth_multiplier #(.WIDTH(4)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .X     (X),
    .Y     (Y),
    .valid (valid),
    .Z     (Z)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  // One multiply. Edges are counted from the capture edge (edge 1), and valid must be seen after edge 5.
  // With glitch set, start is re-asserted with different operands during RUN.
  task automatic do_mul(input logic [3:0] x, input logic [3:0] y, input logic [7:0] exp_z,
                        input bit glitch);
    int n;
    bit seen;
    @(negedge clk);
    X = x; Y = y; start = 1'b1;
    sb.push_back(exp_z);
    @(posedge clk); #1;
    start = 1'b0;
    if (glitch) begin
      X = ~x; Y = y + 4'd5; start = 1'b1;
    end
    n = 1;
    seen = 1'b0;
    while (!seen && n < 20) begin
      @(posedge clk); #1;
      n++;
      if (glitch && n == 3) begin
        start = 1'b0; X = 4'h0; Y = 4'h0;
      end
      if (valid) seen = 1'b1;
      else chk("z_hold_run", Z, last_z);
    end
    if (!seen) chk("valid_timeout", 0, 1);
    else chk("latency_edges", n, 5);
    last_z = exp_z;
    @(posedge clk); #1;
    chk("valid_width", valid, 0);
    chk("z_hold_after", Z, last_z);
  endtask

  initial begin
    int e1, e2, p;
    logic [3:0] xi, yi;

    rst = 1'b1; start = 1'b0; X = '0; Y = '0;

    // Monitor: on every valid, pop the oldest expected product and compare it with Z
    fork
      forever begin
        @(negedge clk);
        if (!rst && valid) begin
          if (sb.size() == 0) begin
            chk("stray_valid", 1, 0);
          end else begin
            chk("product", Z, sb.pop_front());
          end
        end
      end
    join_none

    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", valid, 0);
    chk("rst_z", Z, 0);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_valid", valid, 0);
    chk("post_rst_z", Z, 0);

    // Directed vectors, with expected values computed by hand
    do_mul(4'd2,  4'd3,  8'h06, 1'b0);   //  2 *  3 =   6
    do_mul(4'hD,  4'd4,  8'hF4, 1'b0);   // -3 *  4 = -12
    do_mul(4'hE,  4'hE,  8'h04, 1'b0);   // -2 * -2 =   4
    do_mul(4'h8,  4'h8,  8'h40, 1'b0);   // -8 * -8 =  64
    do_mul(4'd7,  4'h8,  8'hC8, 1'b0);   //  7 * -8 = -56
    do_mul(4'd0,  4'hB,  8'h00, 1'b0);   //  0 * -5 =   0
    do_mul(4'd5,  4'hD,  8'hF1, 1'b1);   //  5 * -3 = -15; start pulsed again during RUN

    // With start held high, the next capture happens in the IDLE cycle right after each valid
    @(negedge clk);
    X = 4'd3; Y = 4'hE; start = 1'b1;    // 3 * -2 = -6
    sb.push_back(8'hFA);
    sb.push_back(8'hFA);
    e1 = -1; e2 = -1;
    for (int k = 0; k < 30 && e2 < 0; k++) begin
      @(posedge clk); #1;
      if (valid) begin
        if (e1 < 0) e1 = k;
        else begin
          e2 = k;
          start = 1'b0;
        end
      end
    end
    start = 1'b0;
    if (e2 < 0) chk("held_start_timeout", 0, 1);
    else chk("held_start_gap", e2 - e1, 5);
    last_z = 8'hFA;
    repeat (8) @(posedge clk);
    #1;
    chk("held_start_idle_z", Z, 8'hFA);

    // Asynchronous reset in the middle of RUN
    @(negedge clk);
    X = 4'd7; Y = 4'd7; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("abort_valid", valid, 0);
    chk("abort_z", Z, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    last_z = 8'h00;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      chk("abort_no_valid", valid, 0);
    end

    // Full sweep, with expected values from a signed reference model
    for (int i = 0; i < 16; i++) begin
      for (int j = 0; j < 16; j++) begin
        xi = 4'(i);
        yi = 4'(j);
        p = $signed(xi) * $signed(yi);
        do_mul(xi, yi, p[7:0], 1'b0);
      end
    end

    repeat (3) @(posedge clk);
    #1;
    chk("sb_empty", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
